// File: rtl/sshled_scan_ctrl.sv
// Scan controller for a bank of multiplexed hex seven-segment digits sharing one segment bus.
// Values are double-buffered and only swap at frame boundaries so a frame is never torn.
module sshled_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 1
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic [4*DIGITS-1:0]   iValue,
   input  logic [DIGITS-1:0]     iDP,
   input  logic                  iLoad,
   input  logic                  iBlankLZ,
   input  logic                  iEnable,
   output logic [6:0]            oSeg,
   output logic                  oDP,
   output logic [DIGITS-1:0]     oDigit,
   output logic                  oFrame
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic                slotEnd;
   logic                frameEnd;

   logic [4*DIGITS-1:0] pendVal;
   logic [DIGITS-1:0]   pendDp;
   logic                pendFlag;
   logic [4*DIGITS-1:0] dispVal;
   logic [DIGITS-1:0]   dispDp;

   logic [3:0]          curNib;
   logic                curDp;
   logic                curSupp;
   logic                zeroAbove;
   logic                inBlank;

   logic [6:0]          segNext;
   logic                dpNext;
   logic [DIGITS-1:0]   digNext;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = 7'h3F;
         4'h1:    code = 7'h06;
         4'h2:    code = 7'h5B;
         4'h3:    code = 7'h4F;
         4'h4:    code = 7'h66;
         4'h5:    code = 7'h6D;
         4'h6:    code = 7'h7D;
         4'h7:    code = 7'h07;
         4'h8:    code = 7'h7F;
         4'h9:    code = 7'h67;
         4'hA:    code = 7'h77;
         4'hB:    code = 7'h7C;
         4'hC:    code = 7'h39;
         4'hD:    code = 7'h5E;
         4'hE:    code = 7'h79;
         default: code = 7'h71;
      endcase
      return code;
   endfunction

   assign slotEnd  = (cnt == CNT_LAST);
   assign frameEnd = slotEnd && (idx == IDX_LAST);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slotEnd) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A load landing on the boundary cycle still leaves the flag set, so it commits one frame later.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         pendVal  <= '0;
         pendDp   <= '0;
         pendFlag <= 1'b0;
         dispVal  <= '0;
         dispDp   <= '0;
      end else begin
         if (frameEnd && pendFlag) begin
            dispVal <= pendVal;
            dispDp  <= pendDp;
         end
         if (iLoad) begin
            pendVal  <= iValue;
            pendDp   <= iDP;
            pendFlag <= 1'b1;
         end else if (frameEnd) begin
            pendFlag <= 1'b0;
         end
      end
   end

   // Walk from the most significant digit down so zeroAbove covers this nibble and all higher ones.
   always_comb begin
      curNib    = 4'h0;
      curDp     = 1'b0;
      curSupp   = 1'b0;
      zeroAbove = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zeroAbove = zeroAbove && (dispVal[4*k +: 4] == 4'h0);
         if (idx == IDX_W'(k)) begin
            curNib  = dispVal[4*k +: 4];
            curDp   = dispDp[k];
            curSupp = iBlankLZ && zeroAbove && (k != 0);
         end
      end
   end

   assign inBlank = (int'(cnt) < BLANK_CYC);

   always_comb begin
      segNext = 7'h7F;
      dpNext  = 1'b1;
      digNext = '1;
      if (iEnable && !inBlank && !curSupp) begin
         segNext = ~glyph(curNib);
         dpNext  = ~curDp;
         for (int k = 0; k < DIGITS; k++) begin
            digNext[k] = (idx != IDX_W'(k));
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         oSeg   <= 7'h7F;
         oDP    <= 1'b1;
         oDigit <= '1;
         oFrame <= 1'b0;
      end else begin
         oSeg   <= segNext;
         oDP    <= dpNext;
         oDigit <= digNext;
         oFrame <= frameEnd;
      end
   end

endmodule
